sim_exit_ctrl: RTL
==================

// Module: sim_exit_ctrl
// PURPOSE
// - Multi-channel, cycle-driven successor to the simulation-exit poller: polls the host mailbox of NumChannels
//   harts/clusters at a fixed interval and records each channel's exit word.
// - Requests host-model cleanup once every channel has exited, then raises a sticky aggregate done/exit code.
// - Sits in the test harness beside the clock/reset generator and drives the final pass/fail report.
// PARAMETERS
// - NumChannels   4     polled mailboxes (1..16)
// - WordWidth     32    mailbox word width; exit code = word >> 1
// - PollCycles    200   clock cycles between poll rounds (>= 1)
// - TimeoutCycles 2**24 watchdog limit in cycles; used only with SIM_EXIT_TIMEOUT_EN
// PORTS
// - clk_i             in  1                       clock
// - rst_i             in  1                       asynchronous reset, active-high
// - poll_req_o        out 1                       poll request to host model
// - poll_ch_o         out $clog2(NumChannels)     channel being polled; stable while poll_req_o=1
// - poll_gnt_i        in  1                       request accepted
// - poll_rsp_valid_i  in  1                       response word valid (1-cycle pulse)
// - poll_rsp_word_i   in  WordWidth               mailbox word
// - cleanup_req_o     out 1                       request host-model cleanup
// - cleanup_ack_i     in  1                       cleanup complete
// - ch_done_o         out NumChannels             per-channel exited flags
// - done_o            out 1                       simulation finished (sticky)
// - exit_code_o       out WordWidth-1             aggregate exit code
// - timeout_o         out 1                       watchdog fired (0 when macro is off)
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, timer=0, channel pointer=0, all ch_done/code registers cleared.
//   Async assert aborts any in-flight poll or cleanup; late gnt/rsp after reset release are ignored in IDLE.
// - FSM states: IDLE, REQ, WAIT_RSP, NEXT, CLEANUP, DONE.
//   - IDLE: timer counts 0..PollCycles-1; at terminal count go to REQ with pointer at lowest not-done channel.
//   - REQ: poll_req_o=1 until poll_gnt_i. gnt in the same cycle as req is valid -> WAIT_RSP on the next edge.
//   - WAIT_RSP: on poll_rsp_valid_i, if word[0]=1 then set ch_done[ptr] and store code=word[WordWidth-1:1];
//     word[0]=0 means "still running", no state change. rsp without a preceding gnt is ignored.
//   - NEXT: advance pointer to the next not-done channel above ptr. If one exists -> REQ (same round), else
//     timer restarts -> IDLE. If all ch_done are set -> CLEANUP.
//   - CLEANUP: cleanup_req_o=1 level until cleanup_ack_i; then DONE.
//   - DONE: done_o=1; exit_code_o = code of lowest-index channel with nonzero code, else 0. Absorbing until reset.
// - A done channel is never re-polled; its code is write-once.
// - Latency: done_o rises exactly 1 cycle after the cleanup_ack_i edge.
//   First poll_req_o rises PollCycles cycles after reset release.
// - Channel codes are held at WordWidth-1 bits; no truncation and no sign handling.
// CONFIGURATION
// - SIM_EXIT_TIMEOUT_EN defined: free-running cycle counter starts at reset release. When it reaches
//   TimeoutCycles in any state except CLEANUP/DONE: timeout_o=1, exit_code_o=all-ones, go to CLEANUP.
//   Timeout is checked before a same-cycle exit response; the response is dropped.
// - SIM_EXIT_TIMEOUT_EN undefined: no counter is instantiated, timeout_o is tied to 0, and the block can hang.
// STRUCTURE
// - sim_exit_pkg: state_e enum, exit_word_t/exit_code_t typedefs, function word_is_exit().
// - Sub-module sim_exit_poll_timer: interval counter with restart input and terminal-count pulse output.
//   It is instantiated once.
// TESTING
// - Ch0 writes word 0x1 at the first poll, then ch1..3 write 0x1 -> 4 polls in one round, cleanup_req_o,
//   ack -> done_o=1, exit_code_o=0.
// - Ch2 writes 0x7 (code 3) and ch1 writes 0x5 (code 2), all exit -> exit_code_o=2 (lowest index nonzero).
// - Host holds poll_gnt_i low 10 cycles -> poll_req_o and poll_ch_o stay stable; no pointer advance.
// - Ch0 exits in round 1, others in round 3 -> ch0 not polled again; ch_done_o=4'b0001 after round 1.
// - Assert rst_i during WAIT_RSP and drive a stray rsp after release -> all outputs 0; rsp ignored;
//   next poll at PollCycles.
// - SIM_EXIT_TIMEOUT_EN with TimeoutCycles=1000 and no exits -> timeout_o=1, exit_code_o=all-ones,
//   cleanup handshake completes, done_o=1.

Source files
------------

// File: rtl/sim_exit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_exit_pkg
// Purpose  : Shared types and helpers for the multi-channel simulation-exit
//            controller: FSM state encoding, mailbox word / exit code types
//            and the mailbox word decode helper.
// Contents : state_e       - controller FSM states
//            exit_word_t   - mailbox word at the default 32-bit width
//            exit_code_t   - exit code at the default width (word >> 1)
//            word_is_exit  - bit 0 of a mailbox word flags "hart has exited"
// Revision : 1.0 - initial release
// ============================================================================
package sim_exit_pkg;

   localparam int unsigned c_word_width = 32;

   typedef logic [c_word_width-1:0] exit_word_t;
   typedef logic [c_word_width-2:0] exit_code_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAIT_RSP = 3'd2,
      ST_NEXT     = 3'd3,
      ST_CLEANUP  = 3'd4,
      ST_DONE     = 3'd5
   } state_e;

   // A mailbox word with bit 0 set carries a final exit code in its upper
   // bits; bit 0 clear means the channel is still running.
   function automatic logic word_is_exit(input exit_word_t word);
      return word[0];
   endfunction

endpackage : sim_exit_pkg
`default_nettype wire

// File: rtl/sim_exit_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : sim_exit_poll_timer
// Purpose  : Poll-interval counter. Counts 0..POLL_CYCLES-1 while restart_i
//            is low and pulses tc_o on the terminal count; held at zero while
//            restart_i is high.
// Ports    : clk_i     in  clock
//            rst_i     in  asynchronous reset, active-high
//            restart_i in  hold counter at zero (controller not idle)
//            tc_o      out terminal-count pulse
// Revision : 1.0 - initial release
// ============================================================================
module sim_exit_poll_timer #(
   parameter  int unsigned POLL_CYCLES = 200,
   localparam int unsigned c_cnt_w     = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic tc_o
);

   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(POLL_CYCLES - 1);

   logic [c_cnt_w-1:0] r_cnt;

   assign tc_o = !restart_i && (r_cnt == c_last);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (restart_i || tc_o) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

endmodule : sim_exit_poll_timer
`default_nettype wire

// File: rtl/sim_exit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sim_exit_ctrl
// Purpose  : Polls the host mailbox of NUM_CHANNELS harts at a fixed interval,
//            records each channel's write-once exit code, requests host-model
//            cleanup once every channel has exited, then raises a sticky
//            done flag with the aggregate exit code.
// Ports    : clk_i, rst_i          clock / asynchronous active-high reset
//            poll_req_o/poll_ch_o  poll request and channel (stable in REQ)
//            poll_gnt_i            poll request accepted
//            poll_rsp_valid_i/     one-cycle mailbox response
//            poll_rsp_word_i
//            cleanup_req_o/        cleanup handshake (level request)
//            cleanup_ack_i
//            ch_done_o             per-channel exited flags
//            done_o                simulation finished (sticky)
//            exit_code_o           code of lowest channel with nonzero code
//            timeout_o             watchdog fired
// Config   : SIM_EXIT_TIMEOUT_EN - enables the TIMEOUT_CYCLES watchdog;
//            without it timeout_o is tied low and the block can wait forever.
// Revision : 1.0 - initial release
// ============================================================================
module sim_exit_ctrl
   import sim_exit_pkg::*;
#(
   parameter  int unsigned NUM_CHANNELS   = 4,
   parameter  int unsigned WORD_WIDTH     = 32,
   parameter  int unsigned POLL_CYCLES    = 200,
   parameter  int unsigned TIMEOUT_CYCLES = 2**24,
   localparam int unsigned c_ptr_w        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   output logic                    poll_req_o,
   output logic [c_ptr_w-1:0]      poll_ch_o,
   input  logic                    poll_gnt_i,
   input  logic                    poll_rsp_valid_i,
   input  logic [WORD_WIDTH-1:0]   poll_rsp_word_i,
   output logic                    cleanup_req_o,
   input  logic                    cleanup_ack_i,
   output logic [NUM_CHANNELS-1:0] ch_done_o,
   output logic                    done_o,
   output logic [WORD_WIDTH-2:0]   exit_code_o,
   output logic                    timeout_o
);

   if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || WORD_WIDTH < 2 ||
       POLL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("sim_exit_ctrl: parameter out of range");
   end

   state_e                                  r_state;
   state_e                                  w_state_nxt;
   logic [c_ptr_w-1:0]                      r_ptr;
   logic [NUM_CHANNELS-1:0]                 r_ch_done;
   logic [NUM_CHANNELS-1:0][WORD_WIDTH-2:0] r_code;
   logic                                    r_timeout;

   logic                    w_tc;
   logic                    w_timeout;
   logic                    w_rsp_exit;
   logic                    w_all_done;
   logic [c_ptr_w-1:0]      w_first_ptr;
   logic [c_ptr_w-1:0]      w_next_ptr;
   logic                    w_next_found;
   logic [WORD_WIDTH-2:0]   w_min_code;

   // ------------------------------------------------------------------------
   // Poll interval timer: runs only while idle, so it restarts from zero on
   // every return to IDLE.
   // ------------------------------------------------------------------------
   sim_exit_poll_timer #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .restart_i (r_state != ST_IDLE),
      .tc_o      (w_tc)
   );

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
`ifdef SIM_EXIT_TIMEOUT_EN
   localparam int unsigned c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_wd_w-1:0] r_wd_cnt;

   // Saturates at the limit so the comparison stays true until the FSM
   // reaches CLEANUP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wd_cnt <= '0;
      end else if (r_wd_cnt != c_wd_w'(TIMEOUT_CYCLES)) begin
         r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
      end
   end

   assign w_timeout = (r_wd_cnt == c_wd_w'(TIMEOUT_CYCLES)) &&
                      (r_state != ST_CLEANUP) && (r_state != ST_DONE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_timeout <= 1'b0;
      end else if (w_timeout) begin
         r_timeout <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign r_timeout = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Channel selection and aggregate code
   // ------------------------------------------------------------------------
   assign w_all_done = &r_ch_done;
   assign w_rsp_exit = poll_rsp_valid_i && word_is_exit(exit_word_t'(poll_rsp_word_i));

   // Descending scans: the last hit is the lowest matching index.
   always_comb begin
      w_first_ptr  = '0;
      w_next_ptr   = '0;
      w_next_found = 1'b0;
      w_min_code   = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (!r_ch_done[i]) begin
            w_first_ptr = c_ptr_w'(i);
         end
         if (!r_ch_done[i] && (i > int'(r_ptr))) begin
            w_next_ptr   = c_ptr_w'(i);
            w_next_found = 1'b1;
         end
         if (r_code[i] != '0) begin
            w_min_code = r_code[i];
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:     if (w_tc)             w_state_nxt = ST_REQ;
         ST_REQ:      if (poll_gnt_i)       w_state_nxt = ST_WAIT_RSP;
         ST_WAIT_RSP: if (poll_rsp_valid_i) w_state_nxt = ST_NEXT;
         ST_NEXT: begin
            if (w_all_done)        w_state_nxt = ST_CLEANUP;
            else if (w_next_found) w_state_nxt = ST_REQ;
            else                   w_state_nxt = ST_IDLE;
         end
         ST_CLEANUP:  if (cleanup_ack_i)    w_state_nxt = ST_DONE;
         ST_DONE:                           w_state_nxt = ST_DONE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
      // Watchdog wins over anything else happening in the same cycle.
      if (w_timeout) begin
         w_state_nxt = ST_CLEANUP;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_ch_done <= '0;
         r_code    <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (r_state == ST_IDLE && w_tc) begin
            r_ptr <= w_first_ptr;
         end else if (r_state == ST_NEXT && w_next_found) begin
            r_ptr <= w_next_ptr;
         end

         // Codes are write-once; a timeout in the same cycle drops the word.
         if (r_state == ST_WAIT_RSP && w_rsp_exit && !w_timeout && !r_ch_done[r_ptr]) begin
            r_ch_done[r_ptr] <= 1'b1;
            r_code[r_ptr]    <= poll_rsp_word_i[WORD_WIDTH-1:1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign poll_req_o    = (r_state == ST_REQ);
   assign poll_ch_o     = r_ptr;
   assign cleanup_req_o = (r_state == ST_CLEANUP);
   assign ch_done_o     = r_ch_done;
   assign done_o        = (r_state == ST_DONE);
   assign timeout_o     = r_timeout;
   assign exit_code_o   = r_timeout           ? '1         :
                          (r_state == ST_DONE) ? w_min_code : '0;

endmodule : sim_exit_ctrl
`default_nettype wire
